// File: rtl/seq_ctrl_pkg.sv
// Shared types and defaults for the frame-level sequence detector controller.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned          DEF_PMAX    = 32'd8;
    localparam logic [DEF_PMAX-1:0]  DEF_RST_PAT = 8'b0000_0101;
    localparam int unsigned          DEF_RST_LEN = 32'd3;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pmax);
        int unsigned res;
        if (len > pmax) begin
            res = pmax;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial Mealy matcher: history, bits-seen counter and masked pattern compare.
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned PMAX = 32'd8,
    parameter int unsigned LW   = 32'd4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            x,
    input  logic            shift_en,
    input  logic            clr,
    input  logic [PMAX-1:0] pat,
    input  logic [LW-1:0]   len,
    output logic            z
);

    logic [PMAX-2:0] hist_r;
    logic [LW-1:0]   seen_r;
    logic [PMAX-1:0] window_s;
    logic [PMAX-1:0] mask_s;
    logic [LW:0]     seen_inc_s;

    // Window is the newest PMAX bits including the bit on x; mask keeps the low len bits.
    always_comb begin
        window_s = {hist_r, x};
        mask_s   = '0;
        for (int i = 0; i < int'(PMAX); i++) begin
            mask_s[i] = (i < int'(len));
        end
    end

    assign seen_inc_s = {1'b0, seen_r} + (LW+1)'(1);
    assign z = shift_en && (len != '0) && (seen_inc_s >= {1'b0, len})
               && (((window_s ^ pat) & mask_s) == '0);

    // History and bits-seen counter; cleared at frame start, advanced once per shifted bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_r <= '0;
            seen_r <= '0;
        end else if (clr) begin
            hist_r <= '0;
            seen_r <= '0;
        end else if (shift_en) begin
            hist_r <= window_s[PMAX-2:0];
            if (seen_r != LW'(PMAX)) begin
                seen_r <= seen_r + LW'(1);
            end else begin
                seen_r <= seen_r;
            end
        end else begin
            hist_r <= hist_r;
            seen_r <= seen_r;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Frame controller: accepts words, serialises them MSB-first into the matcher, counts matches.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned      W       = 32'd8,
    parameter int unsigned      PMAX    = 32'd8,
    parameter int unsigned      CW      = 32'd8,
    parameter logic [PMAX-1:0]  RST_PAT = PMAX'(DEF_RST_PAT),
    parameter int unsigned      RST_LEN = DEF_RST_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [PMAX-1:0]            cfg_pat,
    input  logic [$clog2(PMAX+1)-1:0]  cfg_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_data,
    input  logic                       in_last,
    output logic                       x,
    output logic                       z,
    output logic                       busy,
    output logic                       done,
    output logic [CW-1:0]              match_cnt
);

    localparam int unsigned LW = $clog2(PMAX+1);
    localparam int unsigned BW = (W > 32'd1) ? $clog2(W) : 32'd1;

    state_e          state_r;
    state_e          state_s;
    logic [W-1:0]    sreg_r;
    logic [BW-1:0]   bit_r;
    logic            last_r;
    logic [PMAX-1:0] pat_r;
    logic [LW-1:0]   len_r;
    logic [CW-1:0]   cnt_r;
    logic            accept_s;
    logic            shifting_s;
    logic            clr_s;
    logic            z_s;

    assign in_ready   = (state_r == ST_IDLE) || (state_r == ST_WAIT);
    assign accept_s   = in_valid && in_ready;
    assign shifting_s = (state_r == ST_SHIFT);
    assign clr_s      = accept_s && (state_r == ST_IDLE);
    assign x          = shifting_s && sreg_r[W-1];
    assign z          = z_s;
    assign busy       = shifting_s || (state_r == ST_DONE);
    assign done       = (state_r == ST_DONE);
    assign match_cnt  = cnt_r;

    seq_match_core #(.PMAX(PMAX), .LW(LW)) u_core (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .shift_en (shifting_s),
        .clr      (clr_s),
        .pat      (pat_r),
        .len      (len_r),
        .z        (z_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a word ends when its bit 0 has been presented.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_WAIT: begin
                if (accept_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SHIFT: begin
                if (bit_r == '0) begin
                    state_s = last_r ? ST_DONE : ST_WAIT;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Word capture and MSB-first serialisation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_r <= '0;
            bit_r  <= '0;
            last_r <= 1'b0;
        end else if (accept_s) begin
            sreg_r <= in_data;
            bit_r  <= BW'(W - 32'd1);
            last_r <= in_last;
        end else if (shifting_s) begin
            sreg_r <= {sreg_r[W-2:0], 1'b0};
            bit_r  <= bit_r - BW'(1);
            last_r <= last_r;
        end else begin
            sreg_r <= sreg_r;
            bit_r  <= bit_r;
            last_r <= last_r;
        end
    end

    // Pattern configuration, writable only at a frame boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_r <= RST_PAT;
            len_r <= LW'(clamp_len(RST_LEN, PMAX));
        end else if (cfg_we && (state_r == ST_IDLE)) begin
            pat_r <= cfg_pat;
            len_r <= LW'(clamp_len(32'(cfg_len), PMAX));
        end else begin
            pat_r <= pat_r;
            len_r <= len_r;
        end
    end

    // Saturating match counter; holds after DONE until the next frame starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr_s) begin
            cnt_r <= '0;
        end else if (shifting_s && z_s && (cnt_r != {CW{1'b1}})) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: an 8-bit-counter and a 2-bit-counter instance share stimulus.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pat = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready, x, z, busy, done;
    logic [7:0] match_cnt;
    logic       in_ready2, x2, z2, busy2, done2;
    logic [1:0] cnt2;

    typedef struct {
        logic x;
        logic z;
        logic dn;
        int   cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_hist, m_seen, m_cnt, m_len, m_pat;
    bit   frame_open = 1'b0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.W(8), .PMAX(8), .CW(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .x(x), .z(z), .busy(busy), .done(done), .match_cnt(match_cnt)
    );

    seq_detect_ctrl #(.W(8), .PMAX(8), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .x(x2), .z(z2), .busy(busy2), .done(done2), .match_cnt(cnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic program_cfg(input logic [7:0] p, input logic [3:0] l);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_pat = p; cfg_len = l;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_pat = int'(p);
        m_len = (l > 4'd8) ? 8 : int'(l);
    endtask

    task automatic send_word(input logic [7:0] d, input logic l);
        int   n = 0;
        int   mask, win;
        logic bx, bz;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_ready", in_ready, 1);
        if (!frame_open) begin
            m_hist = 0; m_seen = 0; m_cnt = 0;
        end
        for (int b = 7; b >= 0; b--) begin
            bx   = d[b];
            mask = (1 << m_len) - 1;
            win  = ((m_hist << 1) | int'(bx)) & mask;
            bz   = (m_len != 0) && (m_seen + 1 >= m_len) && (win == (m_pat & mask));
            if (bz) m_cnt++;
            m_hist = (m_hist << 1) | int'(bx);
            m_seen++;
            q.push_back('{x: bx, z: bz, dn: 1'b0, cnt: 0});
        end
        if (l) q.push_back('{x: 1'b0, z: 1'b0, dn: 1'b1, cnt: m_cnt});
        frame_open = !l;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", busy, 0);
    endtask

    // Scoreboard: one expected entry per busy cycle; idle cycles must show x, z and done low.
    always @(negedge clk) begin
        if (rst) begin
            if (busy) begin
                if (q.size() == 0) begin
                    check_eq("busy_unexpected", busy, 0);
                end else begin
                    e = q.pop_front();
                    check_eq("done", done, e.dn);
                    if (e.dn) begin
                        check_eq("done_cnt8", match_cnt, sat(e.cnt, 255));
                        check_eq("done_cnt2", cnt2, sat(e.cnt, 3));
                    end else begin
                        check_eq("x", x, e.x);
                        check_eq("z", z, e.z);
                        check_eq("z_sat", z2, e.z);
                    end
                end
            end else begin
                check_eq("idle_x", x, 0);
                check_eq("idle_z", z, 0);
                check_eq("idle_done", done, 0);
            end
        end
    end

    initial begin
        m_pat = 5; m_len = 3; m_hist = 0; m_seen = 0; m_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_z", z, 0);
        check_eq("rst_cnt", match_cnt, 0);
        rst = 1'b1;

        send_word(8'b1010_1010, 1'b1);
        wait_idle();
        check_eq("default_cnt", match_cnt, 3);

        send_word(8'b0000_0010, 1'b0);
        wait_idle();
        repeat (3) begin
            @(negedge clk);
            check_eq("wait_ready", in_ready, 1);
        end
        send_word(8'b1000_0000, 1'b1);
        wait_idle();
        check_eq("cross_cnt", match_cnt, 1);

        program_cfg(8'b0000_1101, 4'd4);
        send_word(8'b1101_1010, 1'b1);
        cfg_we = 1'b1; cfg_pat = 8'h00; cfg_len = 4'd1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        wait_idle();
        check_eq("reprog_cnt", match_cnt, 2);
        send_word(8'b1101_1010, 1'b1);
        wait_idle();
        check_eq("cfg_ignored_cnt", match_cnt, 2);

        program_cfg(8'hFF, 4'd0);
        send_word(8'hFF, 1'b1);
        wait_idle();
        check_eq("len0_cnt", match_cnt, 0);

        program_cfg(8'hFF, 4'd15);
        send_word(8'hFF, 1'b1);
        wait_idle();
        check_eq("clamp_cnt", match_cnt, 1);

        program_cfg(8'h01, 4'd1);
        send_word(8'hFF, 1'b1);
        wait_idle();
        check_eq("sat_cnt8", match_cnt, 8);
        check_eq("sat_cnt2", cnt2, 3);

        send_word(8'b1010_1010, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_z", z, 0);
        check_eq("midrst_x", x, 0);
        check_eq("midrst_cnt", match_cnt, 0);
        q.delete();
        frame_open = 1'b0;
        m_pat = 5; m_len = 3;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        send_word(8'b1010_1010, 1'b1);
        wait_idle();
        check_eq("revert_cnt", match_cnt, 3);

        repeat (2) @(negedge clk);
        check_eq("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Frame-level controller that sequences a programmable Mealy pattern-detector datapath. It accepts parallel words over a valid/ready handshake and serialises them MSB-first into the detector, one bit per clock. It keeps detector history across the words of a frame, counts overlapping matches and signals frame completion. It sits between a word-oriented producer and the bit-serial `x`/`z` detector interface used by the FSM blocks.

## Interface
- `W`, 8: input word width (≥2)
- `PMAX`, 8: maximum pattern length (≥2)
- `CW`, 8: match counter width
- `RST_PAT`, 'b101: pattern after reset, LSB = most recent bit
- `RST_LEN`, 3: pattern length after reset

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  load `cfg_pat`/`cfg_len`; honoured only in IDLE
- `cfg_pat`  in  PMAX  pattern bits, bit 0 = last bit of sequence
- `cfg_len`  in  clog2(PMAX+1)  pattern length; 0 = matching disabled; >PMAX clamps to PMAX
- `in_valid`  in  1  word offered
- `in_ready`  out  1  controller can accept a word
- `in_data`  in  W  word, sent MSB first
- `in_last`  in  1  word is the last of the frame
- `x`  out  1  serial bit currently presented to the detector
- `z`  out  1  Mealy match; combinational on the current `x` and history
- `busy`  out  1  state is SHIFT or DONE
- `done`  out  1  one-cycle frame-complete pulse
- `match_cnt`  out  CW  matches in the current or last frame; saturates at 2^CW−1

## Operation
- States:
  - IDLE: frame boundary; `in_ready`=1.
  - WAIT: mid-frame; `in_ready`=1.
  - SHIFT: serialising a word; `in_ready`=0.
  - DONE: one cycle; `done`=1, then IDLE.
- Transitions:
  - IDLE → SHIFT on accept. Clears history, bit-seen counter and `match_cnt` at the same edge.
  - SHIFT → WAIT after bit 0 of a non-last word. History is kept; any number of idle cycles is allowed.
  - WAIT → SHIFT on accept.
  - SHIFT → DONE after bit 0 of a last word.
  - DONE → IDLE unconditionally.
- Accept: `in_valid & in_ready` at a rising edge. Captures `in_data` into the shift register and `in_last` into a flag.
- Match rule, evaluated per SHIFT cycle:
  - Window = {history, `x`}, truncated to the low `len` bits.
  - `z` = (window == `cfg_pat` low `len` bits) & (bits seen in frame, including `x`, ≥ `len`) & (`len`≠0).
  - Overlapping matches count.
- Per SHIFT edge:
  - History shifts in `x`.
  - Bits-seen counter increments, saturating at PMAX.
  - `match_cnt` increments if `z`, saturating.
- `match_cnt` holds after DONE until the next frame's first accept.
- `cfg_we` outside IDLE is ignored with no side effects. A pattern change takes effect at the next frame.
- Outside SHIFT, `x`=0 and `z`=0.
- Reset values:
  - state IDLE, `in_ready`=1, `x`=0, `z`=0, `busy`=0, `done`=0, `match_cnt`=0.
  - History and counters 0; pattern = `RST_PAT`, length = `RST_LEN`.

## Timing
- Word accepted at edge k → SHIFT occupies cycles k+1 … k+W; bit W−1 presented in cycle k+1.
- Non-last word: `in_ready`=1 from cycle k+W+1 (WAIT). Minimum W+1 cycles per word.
- Last word: `done`=1 in cycle k+W+1, and `match_cnt` is final in that cycle. IDLE from cycle k+W+2.
- `z` is valid within the same cycle as its `x`; no registered latency.
- Reset mid-operation: all outputs go to reset values asynchronously. The in-flight word is dropped, and there is no `done` pulse.

## Structure
- Package `seq_ctrl_pkg`:
  - state enum (IDLE, WAIT, SHIFT, DONE)
  - default `RST_PAT`/`RST_LEN`
  - helper function for length clamping
- Sub-module `seq_match_core`:
  - holds the history register, bits-seen counter and masked compare
  - inputs: `x`, shift enable, clear, pattern, length
  - output: `z`
- The top level holds the FSM, shift register, last flag, config registers and `match_cnt`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, including mid-SHIFT → `in_ready`=1, `busy`/`done`/`z`/`match_cnt`=0. Pattern reverts to 101, len 3.
- Default pattern: one word 8'b1010_1010 with `in_last` → `z` pulses at bits 3, 5, 7 (cycles k+3, k+5, k+7), `match_cnt`=3, `done` at k+9.
- Cross-word history: 8'b0000_0010, then 3 idle cycles in WAIT, then 8'b1000_0000 with `in_last` → exactly one `z`, on the first bit of word 2; `match_cnt`=1.
- Reprogram: in IDLE, `cfg_we` with pat 4'b1101, len 4; send 8'b1101_1010 last → `z` at bits 4 and 7, `match_cnt`=2. A `cfg_we` pulsed during SHIFT leaves the pattern unchanged.
- Disabled and clamped lengths: len 0 with 8'hFF → no `z`, `match_cnt`=0. len 15 clamps to 8, pattern 8'hFF, word 8'hFF → one `z` on bit 8.
- Saturation: `CW`=2, pattern 1'b1 len 1, word 8'hFF → 8 `z` pulses, `match_cnt`=3.
